// File: rtl/m_mem_arbiter_pkg.sv
// rtl/m_mem_arbiter_pkg.sv - shared types and defaults for the IF/MEM memory arbiter
package m_mem_arbiter_pkg;

  localparam int AW_DEF     = 12;
  localparam int DW_DEF     = 32;
  localparam int CONFLICT_W = 16;

  // Which requester owns the memory read data returning next cycle
  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_I    = 2'd1,
    OWN_D    = 2'd2
  } owner_e;

endpackage

// File: rtl/m_satcnt.sv
// rtl/m_satcnt.sv - saturating up-counter with synchronous clear
module m_satcnt #(
  parameter int           W     = 4,
  parameter logic [W-1:0] LIMIT = '1
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         inc_i,
  input  logic         clr_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != LIMIT)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/m_mem_arbiter.sv
// rtl/m_mem_arbiter.sv - single-port memory arbiter, data port first, IF protected from starvation
module m_mem_arbiter
  import m_mem_arbiter_pkg::*;
#(
  parameter int AW       = AW_DEF,
  parameter int DW       = DW_DEF,
  parameter int MAX_WAIT = 4
) (
  input  logic                  w_clk,
  input  logic                  w_rst_n,
  input  logic                  w_i_req,
  input  logic [AW-1:0]         w_i_addr,
  output logic                  w_i_gnt,
  output logic                  r_i_rvld,
  output logic [DW-1:0]         w_i_rdata,
  input  logic                  w_d_req,
  input  logic                  w_d_we,
  input  logic [AW-1:0]         w_d_addr,
  input  logic [DW-1:0]         w_d_wdata,
  output logic                  w_d_gnt,
  output logic                  r_d_rvld,
  output logic [DW-1:0]         w_d_rdata,
  output logic [AW-1:0]         w_m_addr,
  output logic                  w_m_we,
  output logic [DW-1:0]         w_m_din,
  input  logic [DW-1:0]         w_m_dout,
  output logic [CONFLICT_W-1:0] r_conflicts
);

  localparam logic [3:0] WAIT_LIM = 4'(MAX_WAIT);

  logic [3:0] r_wait;
  owner_e     r_owner_q, r_owner_d;
  logic       both_req;

  assign both_req = w_i_req && w_d_req;

  // Grants are forced low while in reset so no store can slip through
  always_comb begin
    w_i_gnt = 1'b0;
    w_d_gnt = 1'b0;
    if (w_rst_n) begin
      if (both_req) begin
        w_i_gnt = (r_wait == WAIT_LIM);
        w_d_gnt = (r_wait != WAIT_LIM);
      end else begin
        w_i_gnt = w_i_req;
        w_d_gnt = w_d_req;
      end
    end
  end

  assign w_m_addr = w_i_gnt ? w_i_addr : (w_d_gnt ? w_d_addr : '0);
  assign w_m_we   = w_d_gnt && w_d_we;
  assign w_m_din  = w_d_wdata;

  always_comb begin
    r_owner_d = OWN_NONE;
    if (w_i_gnt) begin
      r_owner_d = OWN_I;
    end else if (w_d_gnt && !w_d_we) begin
      r_owner_d = OWN_D;
    end
  end

  always_ff @(posedge w_clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_owner_q <= OWN_NONE;
    end else begin
      r_owner_q <= r_owner_d;
    end
  end

  assign r_i_rvld  = (r_owner_q == OWN_I);
  assign r_d_rvld  = (r_owner_q == OWN_D);
  assign w_i_rdata = w_m_dout;
  assign w_d_rdata = w_m_dout;

  m_satcnt #(.W(4), .LIMIT(WAIT_LIM)) u_wait (
    .clk_i  (w_clk),
    .rst_ni (w_rst_n),
    .inc_i  (w_i_req && !w_i_gnt),
    .clr_i  (w_i_gnt || !w_i_req),
    .cnt_o  (r_wait)
  );

  m_satcnt #(.W(CONFLICT_W), .LIMIT({CONFLICT_W{1'b1}})) u_conflicts (
    .clk_i  (w_clk),
    .rst_ni (w_rst_n),
    .inc_i  (both_req),
    .clr_i  (1'b0),
    .cnt_o  (r_conflicts)
  );

endmodule

// File: tb/tb_m_mem_arbiter.sv
// tb/tb_m_mem_arbiter.sv - randomized self-checking bench for m_mem_arbiter with a behavioural model
module tb_m_mem_arbiter;

  localparam int AW       = 12;
  localparam int DW       = 32;
  localparam int MAX_WAIT = 4;
  localparam int DEPTH    = 1 << AW;

  logic          w_clk = 1'b0;
  logic          w_rst_n = 1'b1;
  logic          w_i_req = 1'b0;
  logic [AW-1:0] w_i_addr = '0;
  logic          w_i_gnt;
  logic          r_i_rvld;
  logic [DW-1:0] w_i_rdata;
  logic          w_d_req = 1'b0;
  logic          w_d_we = 1'b0;
  logic [AW-1:0] w_d_addr = '0;
  logic [DW-1:0] w_d_wdata = '0;
  logic          w_d_gnt;
  logic          r_d_rvld;
  logic [DW-1:0] w_d_rdata;
  logic [AW-1:0] w_m_addr;
  logic          w_m_we;
  logic [DW-1:0] w_m_din;
  logic [DW-1:0] w_m_dout;
  logic [15:0]   r_conflicts;

  m_mem_arbiter #(.AW(AW), .DW(DW), .MAX_WAIT(MAX_WAIT)) dut (
    .w_clk(w_clk), .w_rst_n(w_rst_n),
    .w_i_req(w_i_req), .w_i_addr(w_i_addr), .w_i_gnt(w_i_gnt),
    .r_i_rvld(r_i_rvld), .w_i_rdata(w_i_rdata),
    .w_d_req(w_d_req), .w_d_we(w_d_we), .w_d_addr(w_d_addr), .w_d_wdata(w_d_wdata),
    .w_d_gnt(w_d_gnt), .r_d_rvld(r_d_rvld), .w_d_rdata(w_d_rdata),
    .w_m_addr(w_m_addr), .w_m_we(w_m_we), .w_m_din(w_m_din), .w_m_dout(w_m_dout),
    .r_conflicts(r_conflicts)
  );

  always #5 w_clk = ~w_clk;

  function automatic logic [DW-1:0] init_word(input int a);
    return (32'(a) * 32'h9E37_79B1) ^ 32'hA5A5_0F0F;
  endfunction

  // Memory device: registered read, reloaded with a known pattern while in reset
  logic [DW-1:0] mem [DEPTH];
  always @(posedge w_clk) begin
    if (!w_rst_n) begin
      for (int k = 0; k < DEPTH; k++) mem[k] <= init_word(k);
    end else if (w_m_we) begin
      mem[w_m_addr] <= w_m_din;
    end
    w_m_dout <= mem[w_m_addr];
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference model state
  logic [DW-1:0] ref_mem [DEPTH];
  int            starve;
  int            conf;
  logic          exp_i_rvld, exp_d_rvld;
  logic [DW-1:0] exp_i_data, exp_d_data;
  logic          last_gi, last_gd;

  task automatic model_reset();
    for (int k = 0; k < DEPTH; k++) ref_mem[k] = init_word(k);
    starve = 0; conf = 0;
    exp_i_rvld = 1'b0; exp_d_rvld = 1'b0;
    exp_i_data = '0; exp_d_data = '0;
    last_gi = 1'b0; last_gd = 1'b0;
  endtask

  task automatic step(input logic ir, input logic [AW-1:0] ia, input logic dr, input logic dw,
                      input logic [AW-1:0] da, input logic [DW-1:0] wd);
    logic gi, gd;
    @(negedge w_clk);
    w_rst_n = 1'b1;
    w_i_req = ir; w_i_addr = ia;
    w_d_req = dr; w_d_we = dw; w_d_addr = da; w_d_wdata = wd;
    #1;
    chk("i_rvld", 32'(r_i_rvld), 32'(exp_i_rvld));
    chk("d_rvld", 32'(r_d_rvld), 32'(exp_d_rvld));
    if (exp_i_rvld) chk("i_rdata", w_i_rdata, exp_i_data);
    if (exp_d_rvld) chk("d_rdata", w_d_rdata, exp_d_data);
    chk("conflicts", 32'(r_conflicts), 32'(conf));
    if (ir && dr) begin
      gi = (starve >= MAX_WAIT);
      gd = !gi;
    end else begin
      gi = ir;
      gd = dr;
    end
    chk("i_gnt", 32'(w_i_gnt), 32'(gi));
    chk("d_gnt", 32'(w_d_gnt), 32'(gd));
    chk("m_we", 32'(w_m_we), 32'(gd && dw));
    chk("m_addr", 32'(w_m_addr), gi ? 32'(ia) : (gd ? 32'(da) : 32'd0));
    if (gd && dw) chk("m_din", w_m_din, wd);
    if (gd && dw) ref_mem[da] = wd;
    exp_i_rvld = gi;
    if (gi) exp_i_data = ref_mem[ia];
    exp_d_rvld = gd && !dw;
    if (gd && !dw) exp_d_data = ref_mem[da];
    starve = (ir && !gi) ? ((starve + 1 > MAX_WAIT) ? MAX_WAIT : starve + 1) : 0;
    if (ir && dr && conf < 16'hFFFF) conf++;
    last_gi = gi; last_gd = gd;
  endtask

  task automatic idle();
    step(1'b0, '0, 1'b0, 1'b0, '0, '0);
  endtask

  logic          c_ir, c_dr, c_dw;
  logic [AW-1:0] c_ia, c_da;
  logic [DW-1:0] c_wd;

  initial begin
    model_reset();
    #1 w_rst_n = 1'b0;
    #1;
    chk("rst_i_rvld", 32'(r_i_rvld), 32'd0);
    chk("rst_d_rvld", 32'(r_d_rvld), 32'd0);
    chk("rst_conflicts", 32'(r_conflicts), 32'd0);
    w_i_req = 1'b1; w_d_req = 1'b1; w_d_we = 1'b1;
    #1;
    chk("rst_i_gnt", 32'(w_i_gnt), 32'd0);
    chk("rst_d_gnt", 32'(w_d_gnt), 32'd0);
    chk("rst_m_we", 32'(w_m_we), 32'd0);
    @(posedge w_clk);

    // IF-only streaming fetch
    for (int a = 0; a < 8; a++) step(1'b1, AW'(a), 1'b0, 1'b0, '0, '0);
    idle();

    // Store then load at the same word
    step(1'b0, '0, 1'b1, 1'b1, 12'd5, 32'hDEAD_BEEF);
    step(1'b0, '0, 1'b1, 1'b0, 12'd5, '0);
    idle();
    chk("load_after_store", ref_mem[5], 32'hDEAD_BEEF);

    // Continuous conflict: D,D,D,D,I repeating
    for (int c = 0; c < 15; c++) step(1'b1, AW'(c), 1'b1, 1'b0, AW'(100 + c), '0);
    idle();

    // Simultaneous store and fetch at 9: store first, fetch sees the new word
    step(1'b1, 12'd9, 1'b1, 1'b1, 12'd9, 32'h55);
    chk("sim_store_first", 32'(last_gd), 32'd1);
    step(1'b1, 12'd9, 1'b0, 1'b0, '0, '0);
    idle();

    // Reset while a read is in flight
    step(1'b1, 12'd3, 1'b1, 1'b1, 12'd4, 32'h1234);
    step(1'b1, 12'd3, 1'b0, 1'b0, '0, '0);
    @(negedge w_clk);
    w_rst_n = 1'b0;
    #1;
    chk("midrst_i_rvld", 32'(r_i_rvld), 32'd0);
    chk("midrst_d_rvld", 32'(r_d_rvld), 32'd0);
    chk("midrst_conflicts", 32'(r_conflicts), 32'd0);
    chk("midrst_i_gnt", 32'(w_i_gnt), 32'd0);
    model_reset();
    idle();
    idle();

    // Randomized traffic; requesters hold until granted
    c_ir = 1'b0; c_dr = 1'b0; c_dw = 1'b0; c_ia = '0; c_da = '0; c_wd = '0;
    for (int n = 0; n < 400; n++) begin
      if (!(c_ir && !last_gi)) begin
        c_ir = ($urandom_range(0, 3) != 0);
        c_ia = AW'($urandom_range(0, 15));
      end
      if (!(c_dr && !last_gd)) begin
        c_dr = ($urandom_range(0, 2) != 0);
        c_dw = $urandom_range(0, 1) == 1;
        c_da = AW'($urandom_range(0, 15));
        c_wd = $urandom;
      end
      step(c_ir, c_ia, c_dr, c_dw, c_da, c_wd);
    end
    idle();

    // Drive the conflict counter to saturation
    while (conf < 16'hFFFE) step(1'b1, 12'd1, 1'b1, 1'b0, 12'd2, '0);
    for (int s = 0; s < 3; s++) step(1'b1, 12'd1, 1'b1, 1'b0, 12'd2, '0);
    idle();
    chk("conflicts_sat", 32'(r_conflicts), 32'h0000_FFFF);
    idle();
    chk("conflicts_hold", 32'(r_conflicts), 32'h0000_FFFF);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
